// File: rtl/adc_clk_pkg.sv
// rtl/adc_clk_pkg.sv - shared state encoding and counter sizing for the ADC clock supervisor
package adc_clk_pkg;

    // RUN is the only encoding with bit 2 set, so adc_rst_n and ready follow a single flop.
    typedef enum logic [2:0] {
        RESET_PLL = 3'b000,
        WAIT_LOCK = 3'b001,
        STABILIZE = 3'b011,
        FAULT     = 3'b010,
        RUN       = 3'b100
    } sup_state_t;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (m < 2) m = 2;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for a single asynchronous level
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/adc_pll_supervisor.sv
// rtl/adc_pll_supervisor.sv - ADC clock PLL reset sequencing, lock qualification and retry/fault supervision
module adc_pll_supervisor
    import adc_clk_pkg::*;
#(
    parameter int RST_CYCLES     = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       reinit,
    output logic       pll_rst,
    output logic       adc_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [7:0] lol_cnt
);

    localparam int CW = cnt_width(RST_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES);
    localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    RETRY_MAX    = 4'(MAX_RETRIES);

    sup_state_t    state, state_next;
    logic [CW-1:0] cnt;
    logic          locked_s;
    logic          cnt_clr;
    logic          retry_inc;
    logic          retry_clr;
    logic          lol_inc;

    sync_2ff u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RESET_PLL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        retry_inc  = 1'b0;
        retry_clr  = 1'b0;
        lol_inc    = 1'b0;
        if (reinit) begin
            // reinit also restarts the count when already in RESET_PLL
            state_next = RESET_PLL;
            retry_clr  = 1'b1;
            cnt_clr    = 1'b1;
        end else begin
            case (state)
                RESET_PLL: begin
                    if (cnt == RST_LAST) state_next = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_next = STABILIZE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        if (retry_cnt < RETRY_MAX) begin
                            retry_inc  = 1'b1;
                            state_next = RESET_PLL;
                        end else begin
                            state_next = FAULT;
                        end
                    end
                end
                STABILIZE: begin
                    if (!locked_s) begin
                        state_next = WAIT_LOCK;
                    end else if (cnt == STABLE_LAST) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        lol_inc    = 1'b1;
                        retry_clr  = 1'b1;
                        state_next = RESET_PLL;
                    end
                end
                FAULT:   state_next = FAULT;
                default: state_next = RESET_PLL;
            endcase
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt_clr || (state_next != state)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            retry_cnt <= 4'd0;
        end else if (retry_clr) begin
            retry_cnt <= 4'd0;
        end else if (retry_inc) begin
            retry_cnt <= retry_cnt + 4'd1;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lol_cnt <= 8'd0;
        end else if (lol_inc && (lol_cnt != 8'hFF)) begin
            lol_cnt <= lol_cnt + 8'd1;
        end
    end

    always_comb begin
        pll_rst   = 1'b0;
        adc_rst_n = 1'b0;
        ready     = 1'b0;
        fault     = 1'b0;
        case (state)
            RESET_PLL: pll_rst = 1'b1;
            RUN: begin
                adc_rst_n = 1'b1;
                ready     = 1'b1;
            end
            FAULT: begin
                pll_rst = 1'b1;
                fault   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_adc_pll_supervisor.sv
// tb/tb_adc_pll_supervisor.sv - directed self-checking bench for adc_pll_supervisor
module tb_adc_pll_supervisor;

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       reinit;
    logic       pll_rst;
    logic       adc_rst_n;
    logic       ready;
    logic       fault;
    logic [3:0] retry_cnt;
    logic [7:0] lol_cnt;

    int vectors = 0;
    int errors  = 0;
    int wait_timeouts = 0;

    always #10 refclk = ~refclk;

    adc_pll_supervisor #(
        .RST_CYCLES     (4),
        .STABLE_CYCLES  (8),
        .TIMEOUT_CYCLES (32),
        .MAX_RETRIES    (2)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .reinit     (reinit),
        .pll_rst    (pll_rst),
        .adc_rst_n  (adc_rst_n),
        .ready      (ready),
        .fault      (fault),
        .retry_cnt  (retry_cnt),
        .lol_cnt    (lol_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge refclk);
    endtask

    initial begin
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        reinit     = 1'b0;
        cyc(2);
        check("rst_pll_rst",   32'(pll_rst),   32'd1);
        check("rst_adc_rst_n", 32'(adc_rst_n), 32'd0);
        check("rst_ready",     32'(ready),     32'd0);
        check("rst_fault",     32'(fault),     32'd0);
        check("rst_retry",     32'(retry_cnt), 32'd0);
        check("rst_lol",       32'(lol_cnt),   32'd0);

        // normal bring-up
        rst_n = 1'b1;
        cyc(3);
        check("bring_pll_rst_c3", 32'(pll_rst), 32'd1);
        cyc(1);
        check("bring_pll_rst_c4", 32'(pll_rst), 32'd0);
        check("bring_adc_c4",     32'(adc_rst_n), 32'd0);
        cyc(6);
        pll_locked = 1'b1;
        cyc(10);
        check("bring_ready_early", 32'(ready), 32'd0);
        cyc(1);
        check("bring_ready",    32'(ready),     32'd1);
        check("bring_adc",      32'(adc_rst_n), 32'd1);
        check("bring_pll_rst",  32'(pll_rst),   32'd0);
        check("bring_retry",    32'(retry_cnt), 32'd0);

        // lock glitch during STABILIZE
        reinit = 1'b1;
        cyc(1);
        reinit = 1'b0;
        check("reinit_ready",   32'(ready),   32'd0);
        check("reinit_pll_rst", 32'(pll_rst), 32'd1);
        cyc(6);
        pll_locked = 1'b0;
        cyc(3);
        pll_locked = 1'b1;
        check("glitch_retry", 32'(retry_cnt), 32'd0);
        cyc(1);
        check("glitch_pll_rst", 32'(pll_rst), 32'd0);
        check("glitch_ready_a", 32'(ready),   32'd0);
        cyc(3);
        check("glitch_ready_b", 32'(ready), 32'd0);
        cyc(6);
        check("glitch_ready_c", 32'(ready), 32'd0);
        cyc(1);
        check("glitch_ready",       32'(ready),     32'd1);
        check("glitch_retry_after", 32'(retry_cnt), 32'd0);

        // loss of lock in RUN
        pll_locked = 1'b0;
        cyc(2);
        check("lol_ready_hold", 32'(ready), 32'd1);
        cyc(1);
        check("lol_ready",   32'(ready),     32'd0);
        check("lol_adc",     32'(adc_rst_n), 32'd0);
        check("lol_pll_rst", 32'(pll_rst),   32'd1);
        check("lol_cnt_1",   32'(lol_cnt),   32'd1);
        for (int i = 1; i < 300; i++) begin
            int budget;
            pll_locked = 1'b1;
            budget = 40;
            while (!ready && budget > 0) begin
                cyc(1);
                budget--;
            end
            if (budget == 0) wait_timeouts++;
            pll_locked = 1'b0;
            cyc(3);
        end
        check("lol_wait_timeouts", 32'(wait_timeouts), 32'd0);
        check("lol_cnt_sat",       32'(lol_cnt),       32'd255);

        // no lock: two retries then FAULT
        reinit = 1'b1;
        cyc(1);
        reinit = 1'b0;
        cyc(35);
        check("nolock_retry0",   32'(retry_cnt), 32'd0);
        check("nolock_pll_rst0", 32'(pll_rst),   32'd0);
        cyc(1);
        check("nolock_retry1",   32'(retry_cnt), 32'd1);
        check("nolock_pll_rst1", 32'(pll_rst),   32'd1);
        cyc(36);
        check("nolock_retry2",   32'(retry_cnt), 32'd2);
        cyc(35);
        check("nolock_fault_early", 32'(fault), 32'd0);
        cyc(1);
        check("nolock_fault",   32'(fault),     32'd1);
        check("nolock_pll_rst", 32'(pll_rst),   32'd1);
        check("nolock_adc",     32'(adc_rst_n), 32'd0);
        cyc(50);
        check("fault_hold",       32'(fault),     32'd1);
        check("fault_hold_retry", 32'(retry_cnt), 32'd2);

        // reinit out of FAULT, then reinit colliding with a timeout
        reinit = 1'b1;
        cyc(1);
        reinit = 1'b0;
        check("exit_fault",   32'(fault),     32'd0);
        check("exit_retry",   32'(retry_cnt), 32'd0);
        check("exit_pll_rst", 32'(pll_rst),   32'd1);
        cyc(71);
        check("prio_retry_before", 32'(retry_cnt), 32'd1);
        reinit = 1'b1;
        cyc(1);
        reinit = 1'b0;
        check("prio_retry",   32'(retry_cnt), 32'd0);
        check("prio_pll_rst", 32'(pll_rst),   32'd1);
        pll_locked = 1'b1;
        cyc(3);
        check("prio_rst_c3", 32'(pll_rst), 32'd1);
        check("prio_lol",    32'(lol_cnt), 32'd255);
        cyc(1);
        check("prio_rst_c4", 32'(pll_rst), 32'd0);

        // asynchronous reset mid-STABILIZE
        cyc(3);
        rst_n = 1'b0;
        #2;
        check("arst_pll_rst", 32'(pll_rst),   32'd1);
        check("arst_adc",     32'(adc_rst_n), 32'd0);
        check("arst_ready",   32'(ready),     32'd0);
        check("arst_fault",   32'(fault),     32'd0);
        check("arst_retry",   32'(retry_cnt), 32'd0);
        check("arst_lol",     32'(lol_cnt),   32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
